// File: rtl/light_vga_pkg.sv
// Shared definitions for the traffic-light VGA renderer.
// Covers phase codes, RRRGGGBB colour constants and the default lamp geometry.
package light_vga_pkg;

  typedef enum logic [1:0] {
    PHASE_RED     = 2'd0,
    PHASE_AMBER   = 2'd1,
    PHASE_GREEN   = 2'd2,
    PHASE_INVALID = 2'd3
  } phase_t;

  localparam logic [7:0] COL_BLACK = 8'h00;
  localparam logic [7:0] COL_RED   = 8'hE0;
  localparam logic [7:0] COL_AMBER = 8'hF4;
  localparam logic [7:0] COL_GREEN = 8'h1C;

  localparam logic [7:0] DIM_RED   = 8'h60;
  localparam logic [7:0] DIM_AMBER = 8'h68;
  localparam logic [7:0] DIM_GREEN = 8'h0C;

  // Default lamp geometry in pixels. Amber / single lamp is centred on 640x480.
  // Red sits one pitch above it and green one pitch below.
  localparam int LAMP_X_MIN = 288;
  localparam int LAMP_Y_MIN = 208;
  localparam int LAMP_DIM   = 64;
  localparam int LAMP_STEP  = 96;

  // Colour of a fully lit lamp for a phase; the invalid code stays dark.
  function automatic logic [7:0] full_colour(input phase_t p);
    case (p)
      PHASE_RED:   return COL_RED;
      PHASE_AMBER: return COL_AMBER;
      PHASE_GREEN: return COL_GREEN;
      default:     return COL_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/light_vga_renderer_timing.sv
// VGA raster timing.
// Contains the pixel-rate divider and the horizontal/vertical counters.
// Also decodes sync, visible and end-of-frame from the current counter values.
module vga_timing #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int HW       = $clog2(H_TOTAL + 1),
  localparam int VW       = $clog2(V_TOTAL + 1)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          pix_en,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          hsync_next,
  output logic          vsync_next,
  output logic          visible,
  output logic          frame_end
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS        = HW'(H_VISIBLE);
  localparam logic [HW-1:0] H_SYNC_START = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] H_SYNC_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC);

  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS        = VW'(V_VISIBLE);
  localparam logic [VW-1:0] V_SYNC_START = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] V_SYNC_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DW-1:0] div_cnt;

  // With CLK_DIV=1 div_cnt never leaves 0, so pix_en is permanently high.
  assign pix_en = (div_cnt == DIV_LAST);

  // Clock divider producing one pixel strobe every CLK_DIV system clocks
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       div_cnt <= '0;
    else if (pix_en) div_cnt <= '0;
    else             div_cnt <= div_cnt + 1'b1;
  end

  // Raster counters: h wraps each line, v steps on the h wrap and wraps each frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  assign hsync_next = !((h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END));
  assign vsync_next = !((v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END));
  assign visible    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign frame_end  = pix_en && (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: rtl/light_vga_renderer.sv
// Traffic-light VGA renderer.
// Paints the current phase as a lamp square on a black 640x480@60 screen.
// The phase is latched once per frame so a change never tears the picture.
// Build option LIGHT_HOUSING_EN: draws a three-lamp housing with unlit lamps dimmed.
// Without it a single lamp is drawn.
module light_vga_renderer
  import light_vga_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int LAMP_X0   = LAMP_X_MIN,
  parameter int LAMP_Y0   = LAMP_Y_MIN,
`ifdef LIGHT_HOUSING_EN
  parameter int LAMP_PITCH = LAMP_STEP,
`endif
  parameter int LAMP_SIZE = LAMP_DIM
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] state,
  output logic       hsync,
  output logic       vsync,
  output logic [7:0] rgb,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);

  logic          pix_en;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          hsync_next;
  logic          vsync_next;
  logic          visible;
  logic          frame_end;
  phase_t        state_q;
  logic [7:0]    colour;

  vga_timing #(
    .CLK_DIV   (CLK_DIV),
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK)
  ) u_timing (
    .clk        (clk),
    .reset      (reset),
    .pix_en     (pix_en),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .hsync_next (hsync_next),
    .vsync_next (vsync_next),
    .visible    (visible),
    .frame_end  (frame_end)
  );

  // True when (x,y) lies inside the LAMP_SIZE square whose top edge is y0
  function automatic logic in_lamp(input int x, input int y, input int y0);
    return (x >= LAMP_X0) && (x < LAMP_X0 + LAMP_SIZE) &&
           (y >= y0)      && (y < y0 + LAMP_SIZE);
  endfunction

  // Pixel colour for the current raster position; blanking forces black
  always_comb begin
    colour = COL_BLACK;
    if (visible) begin
`ifdef LIGHT_HOUSING_EN
      if (in_lamp(int'(h_cnt), int'(v_cnt), LAMP_Y0 - LAMP_PITCH))
        colour = (state_q == PHASE_RED) ? COL_RED : DIM_RED;
      else if (in_lamp(int'(h_cnt), int'(v_cnt), LAMP_Y0))
        colour = (state_q == PHASE_AMBER) ? COL_AMBER : DIM_AMBER;
      else if (in_lamp(int'(h_cnt), int'(v_cnt), LAMP_Y0 + LAMP_PITCH))
        colour = (state_q == PHASE_GREEN) ? COL_GREEN : DIM_GREEN;
`else
      if (in_lamp(int'(h_cnt), int'(v_cnt), LAMP_Y0))
        colour = full_colour(state_q);
`endif
    end
  end

  // Pixel-rate output registers, one pixel behind the counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      rgb   <= COL_BLACK;
    end else if (pix_en) begin
      hsync <= hsync_next;
      vsync <= vsync_next;
      rgb   <= colour;
    end
  end

  // Phase latch at end of frame; frame_start marks the clock it takes effect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= PHASE_RED;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_end;
      if (frame_end) state_q <= phase_t'(state);
    end
  end

endmodule

// File: tb/tb_light_vga_renderer.sv
// Testbench for light_vga_renderer on a scaled-down raster so several frames fit in a short run.
// A pixel-index reference model feeds a per-clock scoreboard.
// A table of pixel probes drives phase changes and checks lamp colours.
// Hand-written sequences cover reset values and mid-frame reset.
module tb_light_vga_renderer;

  localparam int D  = 2;
  localparam int HV = 40, HF = 4, HS = 6, HB = 6;
  localparam int VV = 30, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int LX = 16, LY = 12, LS = 8, LP = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] state = 2'd0;
  logic       hsync, vsync, frame_start;
  logic [7:0] rgb;

  light_vga_renderer #(
    .CLK_DIV   (D),
    .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
    .LAMP_X0   (LX),
    .LAMP_Y0   (LY),
`ifdef LIGHT_HOUSING_EN
    .LAMP_PITCH(LP),
`endif
    .LAMP_SIZE (LS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .state       (state),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb         (rgb),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       hs;
    logic       vs;
    logic [7:0] rgb;
    logic       fs;
  } out_t;

  typedef struct {
    int         f;
    int         x;
    int         y;
    logic [1:0] st;
    logic [7:0] exp_s;
    logic [7:0] exp_h;
  } vec_t;

  out_t sb_q[$];
  vec_t vt[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 'h%0h, required 'h%0h (t=%0t)", name, act, req, $time);
  endtask

  function automatic logic [7:0] exp_colour(input int x, input int y, input logic [1:0] sq);
    if (x >= HV || y >= VV) return 8'h00;
    if (x < LX || x >= LX + LS) return 8'h00;
`ifdef LIGHT_HOUSING_EN
    if (y >= LY - LP && y < LY - LP + LS) return (sq == 2'd0) ? 8'hE0 : 8'h60;
    if (y >= LY && y < LY + LS)           return (sq == 2'd1) ? 8'hF4 : 8'h68;
    if (y >= LY + LP && y < LY + LP + LS) return (sq == 2'd2) ? 8'h1C : 8'h0C;
    return 8'h00;
`else
    if (y < LY || y >= LY + LS) return 8'h00;
    case (sq)
      2'd0:    return 8'hE0;
      2'd1:    return 8'hF4;
      2'd2:    return 8'h1C;
      default: return 8'h00;
    endcase
`endif
  endfunction

  // Reference model: counts clock edges since reset and derives the pixel shown
  int         edges = 0;
  logic [1:0] m_sq = 2'd0;
  out_t       m_out = '{hs: 1'b1, vs: 1'b1, rgb: 8'h00, fs: 1'b0};
  bit         sh_ok = 1'b0;
  int         sh_f = 0, sh_x = 0, sh_y = 0;
  int         p, pin, mx, my;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      edges = 0;
      m_sq  = 2'd0;
      m_out = '{hs: 1'b1, vs: 1'b1, rgb: 8'h00, fs: 1'b0};
      sb_q.delete();
      sh_ok = 1'b0;
    end else begin
      edges++;
      m_out.fs = 1'b0;
      if (edges % D == 0) begin
        p   = edges / D - 1;
        pin = p % FT;
        mx  = pin % HT;
        my  = pin / HT;
        m_out.hs  = !(mx >= HV + HF && mx < HV + HF + HS);
        m_out.vs  = !(my >= VV + VF && my < VV + VF + VS);
        m_out.rgb = exp_colour(mx, my, m_sq);
        m_out.fs  = (pin == FT - 1);
        if (pin == FT - 1) m_sq = state;
        sh_ok = 1'b1;
        sh_f  = p / FT;
        sh_x  = mx;
        sh_y  = my;
      end
      sb_q.push_back(m_out);
    end
  end

  // Scoreboard compare and sync/frame interval monitors, sampled on the falling edge
  out_t e;
  int   hs_run = 0, vs_run = 0, last_fs = 0;

  initial forever begin
    @(negedge clk);
    if (reset) begin
      hs_run  = 0;
      vs_run  = 0;
      last_fs = 0;
    end else begin
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("outputs{hs,vs,rgb,fs}", int'({hsync, vsync, rgb, frame_start}),
              int'({e.hs, e.vs, e.rgb, e.fs}));
      end
      if (!hsync) hs_run++;
      else if (hs_run != 0) begin
        check("hsync_low_clks", hs_run, HS * D);
        hs_run = 0;
      end
      if (!vsync) vs_run++;
      else if (vs_run != 0) begin
        check("vsync_low_clks", vs_run, VS * HT * D);
        vs_run = 0;
      end
      if (frame_start) begin
        check("frame_start_interval", edges - last_fs, FT * D);
        last_fs = edges;
      end
    end
  end

  task automatic wait_pixel(input int f, input int x, input int y, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * FT * D; i++) begin
      @(negedge clk);
      if (sh_ok && sh_f == f && sh_x == x && sh_y == y) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check($sformatf("timeout_pixel(%0d,%0d,%0d)", f, x, y), 0, 1);
  endtask

  function automatic logic [7:0] pick(input vec_t v);
`ifdef LIGHT_HOUSING_EN
    return v.exp_h;
`else
    return v.exp_s;
`endif
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    vec_t v;
    //          f   x   y  st  single housing
    vt.push_back('{0,  5,  5, 0, 8'h00, 8'h00});
    vt.push_back('{0, 20,  5, 0, 8'h00, 8'hE0});
    vt.push_back('{0, 20, 11, 0, 8'h00, 8'h00});
    vt.push_back('{0, 15, 12, 0, 8'h00, 8'h00});
    vt.push_back('{0, 16, 12, 0, 8'hE0, 8'h68});
    vt.push_back('{0,  0, 15, 2, 8'h00, 8'h00});
    vt.push_back('{0, 20, 15, 2, 8'hE0, 8'h68});
    vt.push_back('{0, 45, 15, 2, 8'h00, 8'h00});
    vt.push_back('{0, 20, 18, 2, 8'hE0, 8'h68});
    vt.push_back('{0, 23, 19, 2, 8'hE0, 8'h68});
    vt.push_back('{0, 24, 19, 2, 8'h00, 8'h00});
    vt.push_back('{0, 16, 20, 2, 8'h00, 8'h00});
    vt.push_back('{0, 20, 25, 2, 8'h00, 8'h0C});
    vt.push_back('{1, 20,  5, 2, 8'h00, 8'h60});
    vt.push_back('{1, 20, 15, 3, 8'h1C, 8'h68});
    vt.push_back('{1, 23, 19, 3, 8'h1C, 8'h68});
    vt.push_back('{1, 20, 25, 3, 8'h00, 8'h1C});
    vt.push_back('{2, 20,  5, 3, 8'h00, 8'h60});
    vt.push_back('{2, 16, 12, 3, 8'h00, 8'h68});
    vt.push_back('{2, 20, 15, 1, 8'h00, 8'h68});
    vt.push_back('{2, 20, 25, 1, 8'h00, 8'h0C});
    vt.push_back('{3, 20,  5, 1, 8'h00, 8'h60});
    vt.push_back('{3, 20, 15, 1, 8'hF4, 8'hF4});

    // Power-on reset values
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({hsync, vsync, rgb, frame_start}), int'(11'b11_00000000_0));
    #2 reset = 1'b0;

    // Table of pixel probes: compare colour, then apply the record's phase input
    for (int i = 0; i < vt.size(); i++) begin
      v = vt[i];
      wait_pixel(v.f, v.x, v.y, ok);
      if (ok) check($sformatf("rgb(f%0d,%0d,%0d)", v.f, v.x, v.y), int'(rgb), int'(pick(v)));
      state = v.st;
    end

    // Mid-frame asynchronous reset at (30,20) of frame 3, held 3 clocks
    wait_pixel(3, 30, 20, ok);
    #2 reset = 1'b1;
    #1 check("midframe_reset_immediate", int'({hsync, vsync, rgb, frame_start}),
             int'(11'b11_00000000_0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("midframe_reset_hold%0d", i), int'({hsync, vsync, rgb, frame_start}),
            int'(11'b11_00000000_0));
    end
    #2 reset = 1'b0;

    // First frame after release is red even though state is amber; the next is amber
    wait_pixel(0, 20, 5, ok);
    if (ok) check("post_reset_rgb(20,5)", int'(rgb), `ifdef LIGHT_HOUSING_EN 8'hE0 `else 8'h00 `endif);
    wait_pixel(0, 20, 15, ok);
    if (ok) check("post_reset_rgb(20,15)", int'(rgb), `ifdef LIGHT_HOUSING_EN 8'h68 `else 8'hE0 `endif);
    wait_pixel(1, 20, 15, ok);
    if (ok) check("post_reset_next_frame_rgb(20,15)", int'(rgb), 8'hF4);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
